cfu_cmd_issuer: RTL and testbench
=================================

Name: cfu_cmd_issuer

Overview:
- Initiator side of the CFU command/response handshake. Drives a Cfu instance's cmd_* inputs and consumes its rsp_* outputs.
- A host-side producer (a test sequencer or DMA walker) pushes commands into a small command FIFO.
- The block issues one command at a time. Each response is returned on a registered result stream.
- Sits between a software-visible command source and the CFU; lets accelerator kernels be exercised without the CPU.

Parameters:
- CMD_DEPTH, 4, command FIFO depth in entries; power of two, >= 2.
- TIMEOUT_CYCLES, 1024, cycles allowed in WAIT_RSP before abort (used only with the optional feature).
- TIMEOUT_DATA, 32'hDEAD_BEEF, result word delivered on timeout.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- push_valid  in  1  host command valid.
- push_ready  out  1  FIFO can accept a command.
- push_function_id  in  10  function id; bits [9:3] are funct7.
- push_in0  in  32  operand 0.
- push_in1  in  32  operand 1.
- cmd_valid  out  1  command presented to the CFU.
- cmd_ready  in  1  CFU accepts the command.
- cmd_payload_function_id  out  10  issued function id.
- cmd_payload_inputs_0  out  32  issued operand 0.
- cmd_payload_inputs_1  out  32  issued operand 1.
- rsp_valid  in  1  CFU response valid.
- rsp_ready  out  1  issuer accepts the response.
- rsp_payload_outputs_0  in  32  CFU result.
- res_valid  out  1  result word available.
- res_ready  in  1  host consumes the result.
- res_data  out  32  captured result.
- res_timeout  out  1  current result came from a timeout.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- issued_count  out  16  commands accepted by the CFU; wraps at 16'hFFFF -> 0.
- completed_count  out  16  results accepted by the host; wraps at 16'hFFFF -> 0.
- err_stray  out  1  sticky: a response arrived outside WAIT_RSP.

Behaviour:
- Reset (synchronous, active-high):
  - Values: push_ready=1, cmd_valid=0, rsp_ready=0, res_valid=0, res_data=0, res_timeout=0, busy=0, both counters 0, err_stray=0.
  - FIFO emptied; FSM to IDLE.
  - Reset mid-operation discards any in-flight command and any pending result.
- Command FIFO:
  - push_ready = !full.
  - A push is accepted when push_valid && push_ready.
  - When full, push_ready stays 0 even in a cycle where a pop occurs; no push-on-full.
  - Read/write pointers wrap modulo CMD_DEPTH.
  - A simultaneous push and pop when not full leaves the occupancy unchanged.
- FSM states: IDLE, ISSUE, WAIT_RSP, DELIVER.
  - IDLE: when the FIFO is non-empty, register the head into cmd_payload_*, set cmd_valid=1, go to ISSUE.
  - ISSUE:
    - cmd_valid=1; payload held stable until the handshake completes.
    - On cmd_valid && cmd_ready: pop the FIFO, cmd_valid<=0, issued_count+1, go to WAIT_RSP.
    - rsp_ready=0 in this state; a same-cycle rsp_valid is not consumed. The CFU holds it, so it is taken in WAIT_RSP.
  - WAIT_RSP:
    - rsp_ready=1.
    - On rsp_valid: res_data<=rsp_payload_outputs_0, res_valid<=1, res_timeout<=0, go to DELIVER.
  - DELIVER:
    - rsp_ready=0.
    - On res_valid && res_ready: res_valid<=0, completed_count+1.
    - Then, if the FIFO is non-empty, load the next head and go directly to ISSUE; otherwise go to IDLE.
- Latency:
  - Push accepted at edge N into an empty, idle block -> cmd_valid=1 from edge N+2.
  - Response accepted at edge M -> res_valid=1 from edge M+1.
- Exactly one command is outstanding at any time, matching the CFU rule cmd_ready=~rsp_valid.
- busy = (FSM != IDLE) || !empty.
- err_stray: set when rsp_valid is high outside WAIT_RSP and the optional feature is enabled. Without the feature, it is set only if rsp_valid is observed in IDLE with an empty FIFO. Cleared only by reset.

Optional Feature:
- Macro: CFU_ISSUER_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_RSP and increments each WAIT_RSP cycle.
  - On reaching TIMEOUT_CYCLES without rsp_valid: res_data<=TIMEOUT_DATA, res_timeout<=1, res_valid<=1, go to DELIVER.
  - rsp_ready=1 in IDLE and DELIVER as well. A late or stray response is consumed, dropped, and sets err_stray.
- Undefined: no counter; WAIT_RSP waits indefinitely; res_timeout tied 0; rsp_ready asserted only in WAIT_RSP.

Test Plan:
- Single command: push fid=10'h008, in0=3, in1=5. CFU holds cmd_ready=1 and returns 32'd15 one cycle later. Required: cmd_valid at N+2 with matching payload; res_data=15 and res_valid=1; after res_ready, issued_count=completed_count=1 and busy=0.
- Backpressure: cmd_ready=0 for 7 cycles. Required: cmd_valid stays 1 and payload is unchanged every cycle; issued_count increments only on the cycle cmd_ready=1.
- FIFO full: push 5 commands back-to-back with cmd_ready=0 and CMD_DEPTH=4. Required: push_ready=0 after the 4th push; the 5th is held by the producer. All 4 are issued in push order once cmd_ready=1; result order matches.
- Result backpressure: res_ready=0 for 10 cycles while 2 commands are queued. Required: rsp_ready=0 and no second cmd_valid until res_ready; res_data is unchanged.
- Reset mid-op: assert reset during WAIT_RSP with 2 commands queued. Required: the next cycle shows all outputs at reset values and busy=0; a later push issues normally.
- With CFU_ISSUER_TIMEOUT_EN, TIMEOUT_CYCLES=16: the CFU never responds. Required: res_data=32'hDEAD_BEEF and res_timeout=1 after 16 WAIT_RSP cycles. A later rsp_valid is consumed and sets err_stray=1.

Source files
------------

// File: rtl/cfu_cmd_issuer.sv
// cfu_cmd_issuer: initiator side of the CFU cmd/rsp handshake.
// Host commands queue in a small FIFO. They are issued to the CFU one at a
// time, and each response is returned on a registered result stream.
// Optional feature macro: CFU_ISSUER_TIMEOUT_EN (WAIT_RSP timeout, stray-response drop).
//
// Handshakes: every stream (push_*, cmd_*, rsp_*, res_*) transfers on a rising
// edge where valid && ready. A valid held by this block keeps its payload
// stable until that transfer. Only one command is ever outstanding at the CFU.
module cfu_cmd_issuer #(
  parameter int          CMD_DEPTH      = 4,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [9:0]  push_function_id,
  input  logic [31:0] push_in0,
  input  logic [31:0] push_in1,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_timeout,
  output logic        busy,
  output logic [15:0] issued_count,
  output logic [15:0] completed_count,
  output logic        err_stray
);

  localparam int PW = $clog2(CMD_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} state_t;
  state_t state, state_nxt;

  logic [9:0]  fid_mem [CMD_DEPTH];
  logic [31:0] in0_mem [CMD_DEPTH];
  logic [31:0] in1_mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  logic empty, full, push_fire, cmd_fire;
  logic load_cmd, cap_rsp, cap_tmo, res_fire, stray_hit;

  assign empty      = (count == '0);
  assign full       = (count == (PW+1)'(CMD_DEPTH));
  assign push_ready = !full;
  assign push_fire  = push_valid && !full;
  assign cmd_fire   = (state == ISSUE) && cmd_valid && cmd_ready;
  assign busy       = (state != IDLE) || !empty;

`ifdef CFU_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  assign rsp_ready = (state != ISSUE);
  assign stray_hit = rsp_valid && (state != WAIT_RSP);

  // Wait-cycle counter: cleared as WAIT_RSP is entered, counts each WAIT_RSP cycle.
  always_ff @(posedge clk) begin
    if (reset) tmo_cnt <= '0;
    else if (cmd_fire) tmo_cnt <= '0;
    else if (state == WAIT_RSP) tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  assign rsp_ready = (state == WAIT_RSP);
  assign stray_hit = rsp_valid && (state == IDLE) && empty;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    load_cmd  = 1'b0;
    cap_rsp   = 1'b0;
    cap_tmo   = 1'b0;
    res_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load_cmd  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_fire) state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          cap_rsp   = 1'b1;
          state_nxt = DELIVER;
        end
`ifdef CFU_ISSUER_TIMEOUT_EN
        else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          cap_tmo   = 1'b1;
          state_nxt = DELIVER;
        end
`endif
      end
      DELIVER: begin
        if (res_valid && res_ready) begin
          res_fire = 1'b1;
          // The delivered command was popped at issue, so the head is the next one.
          if (!empty) begin
            load_cmd  = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      fid_mem[wr_ptr] <= push_function_id;
      in0_mem[wr_ptr] <= push_in0;
      in1_mem[wr_ptr] <= push_in1;
    end
  end

  // FIFO pointers and occupancy; the pop is the CFU command handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PW'(1);
      if (cmd_fire)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push_fire) - (PW+1)'(cmd_fire);
    end
  end

  // Command/result registers, counters and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid               <= 1'b0;
      cmd_payload_function_id <= '0;
      cmd_payload_inputs_0    <= '0;
      cmd_payload_inputs_1    <= '0;
      res_valid               <= 1'b0;
      res_data                <= '0;
      res_timeout             <= 1'b0;
      issued_count            <= '0;
      completed_count         <= '0;
      err_stray               <= 1'b0;
    end else begin
      if (load_cmd) begin
        cmd_valid               <= 1'b1;
        cmd_payload_function_id <= fid_mem[rd_ptr];
        cmd_payload_inputs_0    <= in0_mem[rd_ptr];
        cmd_payload_inputs_1    <= in1_mem[rd_ptr];
      end else if (cmd_fire) begin
        cmd_valid <= 1'b0;
      end
      if (cmd_fire) issued_count <= issued_count + 16'd1;
      if (cap_rsp || cap_tmo) begin
        res_valid   <= 1'b1;
        res_data    <= cap_tmo ? TIMEOUT_DATA : rsp_payload_outputs_0;
        res_timeout <= cap_tmo;
      end else if (res_fire) begin
        res_valid       <= 1'b0;
        completed_count <= completed_count + 16'd1;
      end
      if (stray_hit) err_stray <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cfu_cmd_issuer.sv
// Testbench for cfu_cmd_issuer: random host/CFU/result traffic plus directed
// scenarios, checked against a queue-based reference of the issuer's contract.
module tb_cfu_cmd_issuer;

  localparam int          DEPTH = 4;
  localparam int          TMO   = 16;
  localparam logic [31:0] TDATA = 32'hDEAD_BEEF;

  logic        clk, reset;
  logic        push_valid, push_ready;
  logic [9:0]  push_function_id;
  logic [31:0] push_in0, push_in1;
  logic        cmd_valid, cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_timeout, busy;
  logic [15:0] issued_count, completed_count;
  logic        err_stray;

  cfu_cmd_issuer #(.CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .TIMEOUT_DATA(TDATA)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_function_id(push_function_id), .push_in0(push_in0), .push_in1(push_in1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_timeout(res_timeout),
    .busy(busy), .issued_count(issued_count), .completed_count(completed_count),
    .err_stray(err_stray)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard state.
  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0]  pf_q[$];               // producer backlog (not yet pushed)
  logic [31:0] p0_q[$], p1_q[$];
  logic [9:0]  cf_q[$];               // accepted, not yet issued (push order)
  logic [31:0] c0_q[$], c1_q[$];
  logic [31:0] exp_q[$];              // expected result words, push order
  int n_issued, n_done;
  bit exp_tmo, late_rsp;

  // Stimulus knobs and CFU model state.
  int ready_pct, res_pct, push_pct, rsp_max_delay;
  bit cfu_mute, cfu_out;
  int cfu_cnt;
  logic [31:0] cfu_res;
  bit prev_push_acc, prev_cmd_acc, prev_rsp_acc;
  bit last_stall;
  logic [9:0]  held_fid;
  logic [31:0] held_in0, held_in1, held_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // CFU behaviour: funct7==1 multiplies, everything else subtracts.
  function automatic logic [31:0] cfu_fn(input logic [9:0] fid, input logic [31:0] a,
                                         input logic [31:0] b);
    if (fid[9:3] == 7'd1) return a * b;
    return a - b;
  endfunction

  task automatic add_cmd(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
    pf_q.push_back(fid); p0_q.push_back(a); p1_q.push_back(b);
  endtask

  task automatic add_rand_cmd();
    add_cmd(10'($urandom_range(0, 1023)), $urandom, $urandom);
  endtask

  // One clock of traffic: drive at negedge, score handshakes, then sample after the edge.
  task automatic cycle();
    bit push_acc, cmd_acc, rsp_acc, res_acc;
    logic [31:0] e;
    @(negedge clk);
    if (prev_push_acc) push_valid = 1'b0;
    if (prev_cmd_acc) begin
      cfu_out = 1'b1;
      cfu_cnt = $urandom_range(0, rsp_max_delay);
      cfu_res = cfu_fn(held_fid, held_in0, held_in1);
    end
    if (prev_rsp_acc) begin
      rsp_valid = 1'b0;
      cfu_out   = 1'b0;
    end
    if (cfu_out && !rsp_valid && !cfu_mute) begin
      if (cfu_cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_payload_outputs_0 = cfu_res;
      end else cfu_cnt--;
    end
    if (!push_valid && pf_q.size() > 0 && $urandom_range(1, 100) <= push_pct) begin
      push_valid       = 1'b1;
      push_function_id = pf_q.pop_front();
      push_in0         = p0_q.pop_front();
      push_in1         = p1_q.pop_front();
    end
    cmd_ready = !rsp_valid && ($urandom_range(1, 100) <= ready_pct);
    res_ready = ($urandom_range(1, 100) <= res_pct);

    if (cfu_out) check("one_outstanding", 32'(cmd_valid), 32'd0);
    if (last_stall) begin
      check("stall_cmd_valid", 32'(cmd_valid), 32'd1);
      check("stall_payload", {cmd_payload_function_id[7:0], cmd_payload_inputs_0[11:0],
                              cmd_payload_inputs_1[11:0]},
            {held_fid[7:0], held_in0[11:0], held_in1[11:0]});
    end
    push_acc = push_valid && push_ready;
    if (push_acc) begin
      cf_q.push_back(push_function_id); c0_q.push_back(push_in0); c1_q.push_back(push_in1);
      exp_q.push_back(cfu_fn(push_function_id, push_in0, push_in1));
    end
    cmd_acc = cmd_valid && cmd_ready;
    if (cmd_acc) begin
      if (cf_q.size() == 0) check("issue_unexpected", 32'd1, 32'd0);
      else begin
        check("issue_fid", 32'(cmd_payload_function_id), 32'(cf_q.pop_front()));
        check("issue_in0", cmd_payload_inputs_0, c0_q.pop_front());
        check("issue_in1", cmd_payload_inputs_1, c1_q.pop_front());
      end
      n_issued++;
    end
    last_stall = cmd_valid && !cmd_ready;
    held_fid = cmd_payload_function_id; held_in0 = cmd_payload_inputs_0;
    held_in1 = cmd_payload_inputs_1;
    rsp_acc = rsp_valid && rsp_ready;
    res_acc = res_valid && res_ready;
    if (res_acc) begin
      if (exp_q.size() == 0) check("result_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("result_data", res_data, exp_tmo ? TDATA : e);
        check("result_timeout", 32'(res_timeout), 32'(exp_tmo));
        exp_tmo = 1'b0;
      end
      n_done++;
    end
    @(posedge clk); #1;
    if (rsp_acc) check(late_rsp ? "late_rsp_dropped" : "rsp_to_res_latency",
                       32'(res_valid), late_rsp ? 32'd0 : 32'd1);
    if (cmd_acc) check("issued_count", 32'(issued_count), 32'(n_issued[15:0]));
    if (res_acc) check("completed_count", 32'(completed_count), 32'(n_done[15:0]));
    prev_push_acc = push_acc; prev_cmd_acc = cmd_acc; prev_rsp_acc = rsp_acc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    push_valid = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; res_ready = 1'b0;
    push_function_id = '0; push_in0 = '0; push_in1 = '0; rsp_payload_outputs_0 = '0;
    pf_q.delete(); p0_q.delete(); p1_q.delete();
    cf_q.delete(); c0_q.delete(); c1_q.delete(); exp_q.delete();
    n_issued = 0; n_done = 0; exp_tmo = 0; late_rsp = 0;
    cfu_out = 0; cfu_mute = 0; cfu_cnt = 0;
    prev_push_acc = 0; prev_cmd_acc = 0; prev_rsp_acc = 0; last_stall = 0;
    @(posedge clk); #1;
    check("rst_push_ready", 32'(push_ready), 32'd1);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
`ifdef CFU_ISSUER_TIMEOUT_EN
    check("rst_rsp_ready", 32'(rsp_ready), 32'd1);
`else
    check("rst_rsp_ready", 32'(rsp_ready), 32'd0);
`endif
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_timeout", 32'(res_timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_issued", 32'(issued_count), 32'd0);
    check("rst_completed", 32'(completed_count), 32'd0);
    check("rst_err_stray", 32'(err_stray), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      cycle();
      ok = (pf_q.size() == 0) && !push_valid && (exp_q.size() == 0) && !busy;
    end
    check({tag, "_drained"}, 32'(ok), 32'd1);
    check({tag, "_issued_total"}, 32'(issued_count), 32'(n_issued[15:0]));
    check({tag, "_completed_total"}, 32'(completed_count), 32'(n_done[15:0]));
  endtask

  initial begin
    bit hit;
    int ic;
    reset = 1'b1;
    ready_pct = 100; res_pct = 100; push_pct = 100; rsp_max_delay = 0;
    do_reset();

    // Single command with latency checks.
    res_pct = 0;
    add_cmd(10'h008, 32'd3, 32'd5);
    cycle();
    check("lat_push_edge_cmd_valid", 32'(cmd_valid), 32'd0);
    check("lat_busy_after_push", 32'(busy), 32'd1);
    cycle();
    check("lat_n2_cmd_valid", 32'(cmd_valid), 32'd1);
    check("lat_n2_fid", 32'(cmd_payload_function_id), 32'h008);
    check("lat_n2_in0", cmd_payload_inputs_0, 32'd3);
    check("lat_n2_in1", cmd_payload_inputs_1, 32'd5);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin cycle(); hit = res_valid; end
    check("single_res_valid", 32'(hit), 32'd1);
    check("single_res_data", res_data, 32'd15);
    res_pct = 100;
    drain("single");
    check("single_busy", 32'(busy), 32'd0);

    // Command backpressure: 7 stalled cycles, then one accept.
    ready_pct = 0;
    add_rand_cmd();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin cycle(); hit = cmd_valid; end
    check("bp_cmd_valid_seen", 32'(hit), 32'd1);
    ic = n_issued;
    repeat (7) begin
      cycle();
      check("bp_issued_hold", 32'(issued_count), 32'(ic));
    end
    ready_pct = 100;
    cycle();
    check("bp_issued_step", 32'(issued_count), 32'(ic + 1));
    drain("bp");

    // FIFO full: five back-to-back pushes while the CFU stalls.
    ready_pct = 0; rsp_max_delay = 2;
    ic = exp_q.size();
    repeat (5) add_rand_cmd();
    repeat (10) cycle();
    check("full_push_ready", 32'(push_ready), 32'd0);
    check("full_fifth_held", 32'(push_valid), 32'd1);
    check("full_accepted", 32'(exp_q.size() - ic), 32'd4);
    ready_pct = 100;
    drain("full");

    // Result backpressure with two commands queued.
    res_pct = 0; rsp_max_delay = 0;
    add_rand_cmd(); add_rand_cmd();
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin cycle(); hit = res_valid; end
    check("rbp_res_valid", 32'(hit), 32'd1);
    repeat (10) begin
      cycle();
      check("rbp_rsp_ready", 32'(rsp_ready), 32'd0);
      check("rbp_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rbp_res_data", res_data, exp_q[0]);
    end
    res_pct = 100;
    drain("rbp");

    // Reset while waiting for a response with two commands still queued.
    cfu_mute = 1;
    ic = n_issued;
    repeat (3) add_rand_cmd();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin cycle(); hit = (n_issued != ic); end
    repeat (4) cycle();
    check("midop_queued", 32'(cf_q.size()), 32'd2);
    check("midop_busy", 32'(busy), 32'd1);
    do_reset();
    add_rand_cmd();
    drain("post_reset");

    // Randomized traffic.
    ready_pct = 70; res_pct = 70; push_pct = 60; rsp_max_delay = 3;
    repeat (60) add_rand_cmd();
    drain("random");
    check("random_no_stray", 32'(err_stray), 32'd0);

`ifdef CFU_ISSUER_TIMEOUT_EN
    // CFU never answers: the issuer delivers the timeout word after TMO wait cycles.
    ready_pct = 100; res_pct = 0; push_pct = 100; rsp_max_delay = 0;
    cfu_mute = 1;
    ic = n_issued;
    add_rand_cmd();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin cycle(); hit = (n_issued != ic); end
    check("tmo_issued", 32'(hit), 32'd1);
    repeat (TMO - 1) cycle();
    check("tmo_not_yet", 32'(res_valid), 32'd0);
    cycle();
    check("tmo_res_valid", 32'(res_valid), 32'd1);
    check("tmo_res_data", res_data, TDATA);
    check("tmo_res_timeout", 32'(res_timeout), 32'd1);
    exp_tmo = 1; res_pct = 100;
    repeat (2) cycle();
    check("tmo_idle", 32'(busy), 32'd0);
    late_rsp = 1; cfu_mute = 0;
    repeat (4) cycle();
    check("tmo_late_err_stray", 32'(err_stray), 32'd1);
    check("tmo_late_no_result", 32'(res_valid), 32'd0);
    do_reset();
`endif

    // Stray response while idle with an empty FIFO.
    @(negedge clk);
    cmd_ready = 1'b0; res_ready = 1'b0;
    rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'h1234_5678;
    @(posedge clk); #1;
    @(negedge clk);
    rsp_valid = 1'b0;
    @(posedge clk); #1;
    check("stray_err", 32'(err_stray), 32'd1);
    check("stray_no_result", 32'(res_valid), 32'd0);
    check("stray_busy", 32'(busy), 32'd0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
